i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
- Receive-side counterpart of the team's I2C write master; sits on the SCL/SDA pair driven by that master.
- Oversamples SCL/SDA on the system clock, detects START/STOP and deframes one write transaction: 7-bit id, then 8-bit data, both LSB first, no R/W bit.
- Presents the received byte to the local datapath with a one-cycle valid strobe when the id matches.

Parameters:
- DEV_ID, 7'h2A, this device's 7-bit address; frames with another id are discarded.
- SYNC_STAGES, 2, flip-flop stages on each of scl/sda before edge detection; legal range 2..4.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1).
- scl  input  1  bus clock from the master, asynchronous to clk.
- sda  input  1  bus data from the master, asynchronous to clk.
- id_out  output  7  id of the last accepted frame.
- data_out  output  8  data byte of the last accepted frame; held until the next accept.
- valid  output  1  one-clk pulse: id_out/data_out updated with a matching, complete frame.
- frame_err  output  1  one-clk pulse: frame aborted (short frame, overlong frame, or restart).
- busy  output  1  high from START detect until STOP detect or abort.

Behaviour:
- Reset values: id_out=0, data_out=0, valid=0, frame_err=0, busy=0, FSM=IDLE, bit counter=0, all sync flops=1 (idle bus).
- Sync: scl_s/sda_s = last stage of SYNC_STAGES chain; scl_q/sda_q = one further register for edge detection.
- Events, evaluated each clk: START = sda_q=1, sda_s=0, scl_s=1. STOP = sda_q=0, sda_s=1, scl_s=1. RISE = scl_q=0, scl_s=1. START/STOP take priority over RISE in the same cycle.
- Bit sampling: on RISE, sda_s is shifted in LSB first; the shift register is 15 bits (id[0..6] then data[0..7]); bit counter 0..15, saturates at 15.
- FSM states:
  - IDLE: busy=0. START -> ADDR, counter cleared.
  - ADDR: receive bits 0..6. After the 7th RISE -> DATA.
  - DATA: receive bits 7..14. After the 15th RISE -> WAIT_STOP.
  - WAIT_STOP: STOP -> IDLE. Accept if the received id equals DEV_ID.
- Accept: on the clk edge after STOP is detected in WAIT_STOP, id_out/data_out load and valid=1 for exactly one cycle. Latency from the raw sda rise is SYNC_STAGES+2 clk.
- Id mismatch: return to IDLE silently. No valid, no frame_err, outputs unchanged.
- STOP in ADDR or DATA (short frame): frame_err pulse, -> IDLE, outputs unchanged.
- RISE in WAIT_STOP (extra bit): frame_err pulse, -> IDLE; the bus is ignored until the next START.
- START in ADDR, DATA or WAIT_STOP (repeated start): frame_err pulse, partial frame discarded, -> ADDR with counter cleared.
- SDA changes while SCL is high that are neither START nor STOP do not occur; SDA is only examined at RISE.
- Reset mid-frame: immediate return to reset values, and any in-progress valid is cancelled.
- valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro I2C_SLAVE_RX_ACK_EN.
- When defined: adds output sda_oe (1 bit, reset 0, 1 = pull SDA low).
  - Frame becomes id(7), ACK slot, data(8), ACK slot.
  - sda_oe asserts on the SCL falling edge after bit 6 when the id matches, and after bit 14; it releases on the next SCL falling edge.
  - The ACK-slot RISE is not shifted in.
  - On id mismatch, no ACK is driven and the FSM still consumes the ACK slot before ignoring the frame.
- When undefined: no sda_oe port, no ACK slots; frame timing is exactly as above.

Decomposition:
- Package i2c_pkg: FSM state enum (IDLE, ADDR, DATA, WAIT_STOP); constants ID_BITS=7, DATA_BITS=8, FRAME_BITS=15.
- The master also uses these widths, so they live in the package.
- One sub-module: i2c_bus_sync. It holds the SYNC_STAGES synchronizer plus edge registers for scl/sda and outputs the start/stop/rise event pulses. It is reusable by a future master receive path.

Test Plan:
- Master frame id=7'h2A, data=8'hA5 -> exactly one valid pulse, id_out=7'h2A, data_out=8'hA5, valid SYNC_STAGES+2 clk after STOP, frame_err never high.
- Frame id=7'h15, data=8'h3C (mismatch) -> no valid, no frame_err, data_out retains the previous 8'hA5, busy falls after STOP.
- START, 4 id bits, STOP -> one frame_err pulse, no valid, FSM back in IDLE; a following good frame with data 8'h01 is accepted.
- Repeated START after 10 bits, then a full frame with data 8'hFF -> one frame_err at the restart, then valid with data_out=8'hFF.
- Assert rst_n during the data phase, then release and send data 8'h5A -> outputs at reset values during reset, the second frame is accepted normally.
- With I2C_SLAVE_RX_ACK_EN: frame id=7'h2A with ACK clocks -> sda_oe=1 exactly during both ACK-slot SCL-high periods; with id=7'h15, sda_oe stays 0.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared widths and FSM encoding for the I2C write path
//             (write master and receive slave).
//  Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

  localparam int ID_BITS    = 7;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = ID_BITS + DATA_BITS;  // 15
  localparam int CNT_W      = 4;                    // counts 0..15

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR      = 2'd1,
    DATA      = 2'd2,
    WAIT_STOP = 2'd3
  } i2c_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_bus_sync
//  Purpose  : Synchronises SCL/SDA into the clk domain and produces
//             registered one-cycle START / STOP / SCL-rise / SCL-fall pulses.
//             The sampled SDA is delayed to stay aligned with the pulses.
//             SYNC_STAGES must lie in 2..4.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,     // asynchronous, active-high
  input  logic scl_i,
  input  logic sda_i,
  output logic start_o,
  output logic stop_o,
  output logic rise_o,
  output logic fall_o,
  output logic sda_o      // sampled SDA, aligned with the event pulses
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_q, sda_q;
  logic start_q, stop_q, rise_q, fall_q;

  logic scl_s, sda_s;
  logic start_d, stop_d, rise_d, fall_d;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Bus conditions; START/STOP mask SCL edges in the same cycle
  always_comb begin
    start_d = sda_q & ~sda_s & scl_s;
    stop_d  = ~sda_q & sda_s & scl_s;
    rise_d  = ~scl_q & scl_s & ~start_d & ~stop_d;
    fall_d  = scl_q & ~scl_s & ~start_d & ~stop_d;
  end

  // Synchroniser chains (idle bus = 1), edge registers and event pulses
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign start_o = start_q;
  assign stop_o  = stop_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign sda_o   = sda_q;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_rx
//  Purpose  : Receives one I2C write frame (7-bit id + 8-bit data, LSB first,
//             no R/W bit) and strobes valid when the id equals DEV_ID.
//             Optional macro I2C_SLAVE_RX_ACK_EN adds ACK slots after the id
//             and the data byte, driven through the sda_oe output.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [ID_BITS-1:0] DEV_ID      = 7'h2A,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,      // asynchronous, active-high
  input  logic                 scl,
  input  logic                 sda,
  output logic [ID_BITS-1:0]   id_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef I2C_SLAVE_RX_ACK_EN
  ,
  output logic                 sda_oe
`endif
);

  localparam logic [CNT_W-1:0] LAST_ID_BIT = CNT_W'(ID_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(FRAME_BITS);

  logic ev_start, ev_stop, ev_rise, ev_fall, sda_smp;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_i  (scl),
    .sda_i  (sda),
    .start_o(ev_start),
    .stop_o (ev_stop),
    .rise_o (ev_rise),
    .fall_o (ev_fall),
    .sda_o  (sda_smp)
  );

  i2c_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic                   bit_q, bit_d;        // SDA sampled at the last RISE
  logic                   seen_q, seen_d;      // a RISE is waiting for its FALL
  logic [ID_BITS-1:0]     id_q, id_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [FRAME_BITS-1:0]  shift_nx;
`ifdef I2C_SLAVE_RX_ACK_EN
  logic                   ack_q, ack_d;        // next slot is an ACK slot
  logic                   oe_q, oe_d;
`endif

  assign shift_nx = {bit_q, shift_q[FRAME_BITS-1:1]};

  // Frame FSM: SDA is sampled on RISE but a bit is only committed on the
  // following FALL, so the SCL rise that precedes STOP or a repeated START
  // is never counted as a bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    seen_d  = seen_q;
    id_d    = id_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef I2C_SLAVE_RX_ACK_EN
    ack_d   = ack_q;
    oe_d    = oe_q;
`endif

    if (ev_rise) begin
      bit_d  = sda_smp;
      seen_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ev_start) begin
          state_d = ADDR;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      end

      default: begin
        if (ev_start) begin
          // repeated start: discard the partial frame and restart
          err_d   = 1'b1;
          state_d = ADDR;
          cnt_d   = '0;
          seen_d  = 1'b0;
`ifdef I2C_SLAVE_RX_ACK_EN
          ack_d   = 1'b0;
          oe_d    = 1'b0;
`endif
        end else if (ev_stop) begin
          state_d = IDLE;
          seen_d  = 1'b0;
`ifdef I2C_SLAVE_RX_ACK_EN
          ack_d   = 1'b0;
          oe_d    = 1'b0;
`endif
          if (state_q == WAIT_STOP) begin
            if (shift_q[ID_BITS-1:0] == DEV_ID) begin
              valid_d = 1'b1;
              id_d    = shift_q[ID_BITS-1:0];
              data_d  = shift_q[FRAME_BITS-1:ID_BITS];
            end
          end else begin
            err_d = 1'b1;                          // short frame
          end
        end else if (ev_fall && seen_q) begin
          seen_d = 1'b0;
          if (state_q == WAIT_STOP) begin
            err_d   = 1'b1;                        // extra bit
            state_d = IDLE;
`ifdef I2C_SLAVE_RX_ACK_EN
          end else if (ack_q) begin
            // end of an ACK slot: release SDA, never shift the slot in
            ack_d = 1'b0;
            oe_d  = 1'b0;
            if (state_q == ADDR) begin
              state_d = (shift_q[FRAME_BITS-1:DATA_BITS] == DEV_ID) ? DATA : IDLE;
            end else begin
              state_d = WAIT_STOP;
            end
`endif
          end else begin
            shift_d = shift_nx;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == LAST_ID_BIT) begin
`ifdef I2C_SLAVE_RX_ACK_EN
              ack_d = 1'b1;
              oe_d  = (shift_nx[FRAME_BITS-1:DATA_BITS] == DEV_ID);
`else
              state_d = DATA;
`endif
            end else if (cnt_q == LAST_BIT) begin
`ifdef I2C_SLAVE_RX_ACK_EN
              ack_d = 1'b1;
              oe_d  = 1'b1;
`else
              state_d = WAIT_STOP;
`endif
            end
          end
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= 1'b0;
      seen_q  <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef I2C_SLAVE_RX_ACK_EN
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      seen_q  <= seen_d;
      id_q    <= id_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef I2C_SLAVE_RX_ACK_EN
      ack_q   <= ack_d;
      oe_q    <= oe_d;
`endif
    end
  end

  assign id_out    = id_q;
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);
`ifdef I2C_SLAVE_RX_ACK_EN
  assign sda_oe    = oe_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave_rx
//  Purpose  : Randomised frame stimulus with a frame-level reference model;
//             a monitor scoreboards valid / frame_err against expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave_rx;

  localparam logic [6:0] DEV  = 7'h2A;
  localparam int         SYNC = 3;
  localparam int         Q    = 4;     // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;            // active-high reset
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic [6:0] id_out;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;
`ifdef I2C_SLAVE_RX_ACK_EN
  logic       sda_oe;
`endif

  i2c_slave_rx #(.DEV_ID(DEV), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .id_out   (id_out),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
`ifdef I2C_SLAVE_RX_ACK_EN
    ,
    .sda_oe   (sda_oe)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] id;
    logic [7:0] data;
  } acc_t;

  acc_t acc_q[$];
  int   err_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_stop_cyc = 0;
  bit   bus_active = 0;
  logic [6:0] exp_id = '0;
  logic [7:0] exp_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output strobe must match the head of a scoreboard queue
  always @(negedge clk) begin
    if (!rst_n) begin
      if (valid) begin
        acc_t e;
        chk("valid_excl_err", 32'(frame_err), 32'd0);
        chk("valid_expected", 32'(acc_q.size() > 0), 32'd1);
        if (acc_q.size() > 0) begin
          e = acc_q.pop_front();
          chk("acc_id", 32'(id_out), 32'(e.id));
          chk("acc_data", 32'(data_out), 32'(e.data));
          chk("valid_latency", 32'(cyc - last_stop_cyc), 32'(SYNC + 2));
        end
      end else if (frame_err) begin
        chk("err_expected", 32'(err_q.size() > 0), 32'd1);
        if (err_q.size() > 0) void'(err_q.pop_front());
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();   // bus idle -> START, SCL left low
    sda = 1'b0; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic do_rstart();  // SCL low -> repeated START, SCL left low
    sda = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    sda = 1'b0; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic do_stop();    // SCL low -> STOP, bus idle
    sda = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    sda = 1'b1; last_stop_cyc = cyc;
    wq(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda = b; wq(Q);
    scl = 1'b1; wq(Q);
`ifdef I2C_SLAVE_RX_ACK_EN
    chk("sda_oe_data_bit", 32'(sda_oe), 32'd0);
`endif
    wq(Q);
    scl = 1'b0; wq(Q);
  endtask

`ifdef I2C_SLAVE_RX_ACK_EN
  task automatic ack_slot(input logic exp);
    sda = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    chk("sda_oe_ack", 32'(sda_oe), 32'(exp));
    wq(Q);
    scl = 1'b0; wq(Q);
  endtask
`endif

  // Drives n bit slots: id LSB first, then data LSB first, then random extras
  task automatic send_bits(input logic [6:0] id, input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < 7)       send_bit(id[i]);
      else if (i < 15) send_bit(data[i-7]);
      else             send_bit(1'($urandom_range(0, 1)));
      if (i == 0) chk("busy_in_frame", 32'(busy), 32'd1);
`ifdef I2C_SLAVE_RX_ACK_EN
      if (i == 6 || i == 14) ack_slot(id == DEV);
`endif
    end
  endtask

  // Reference model at frame level: exactly 15 bits closed by STOP is a frame
  // (accepted if the id matches); anything else aborts with one error.
  task automatic model(input logic [6:0] id, input logic [7:0] data, input int n, input bit stop);
    acc_t e;
`ifdef I2C_SLAVE_RX_ACK_EN
    if (id != DEV && n >= 7) return;   // rejected at the id ACK slot, ignored
`endif
    if (stop && n == 15) begin
      if (id == DEV) begin
        e.id = id; e.data = data;
        acc_q.push_back(e);
        exp_id = id; exp_data = data;
      end
    end else begin
      err_q.push_back(1);
    end
  endtask

  task automatic run_frame(input logic [6:0] id, input logic [7:0] data, input int n, input bit stop);
    model(id, data, n, stop);
    if (bus_active) do_rstart();
    else            do_start();
    bus_active = 1;
    send_bits(id, data, n);
    if (stop) begin
      do_stop();
      bus_active = 0;
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("id_out_held", 32'(id_out), 32'(exp_id));
      chk("data_out_held", 32'(data_out), 32'(exp_data));
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_id_out", 32'(id_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef I2C_SLAVE_RX_ACK_EN
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
`endif
  endtask

  initial begin
    int  n;
    bit  stp;
    logic [6:0] rid;
    wq(5);
    chk_reset_vals();
    rst_n = 1'b0;
    wq(2 * Q);

    run_frame(DEV, 8'hA5, 15, 1'b1);              // good frame
    run_frame(7'h15, 8'h3C, 15, 1'b1);            // id mismatch: silent
    run_frame(DEV, 8'h00, 4, 1'b1);               // short frame
    run_frame(DEV, 8'h01, 15, 1'b1);
    run_frame(DEV, 8'(($urandom)), 10, 1'b0);     // restart after 10 bits
    run_frame(DEV, 8'hFF, 15, 1'b1);
    run_frame(DEV, 8'h77, 16, 1'b1);              // one bit too many
    run_frame(DEV, 8'h42, 15, 1'b0);              // restart in WAIT_STOP
    run_frame(DEV, 8'h24, 15, 1'b1);

    // reset during the data phase
    do_start(); bus_active = 1;
    send_bits(DEV, 8'hC3, 10);
    rst_n = 1'b1;
    wq(3);
    chk_reset_vals();
    sda = 1'b1; scl = 1'b1;
    wq(Q);
    chk_reset_vals();
    rst_n = 1'b0; bus_active = 0;
    exp_id = '0; exp_data = '0;
    wq(2 * Q);
    run_frame(DEV, 8'h5A, 15, 1'b1);

    // randomised frames
    for (int k = 0; k < 40; k++) begin
      rid = ($urandom_range(0, 2) != 0) ? DEV : 7'($urandom);
      n   = ($urandom_range(0, 9) < 6) ? 15 : int'($urandom_range(1, 16));
      stp = (k == 39) || ($urandom_range(0, 4) != 0);
      run_frame(rid, 8'($urandom), n, stp);
    end

    wq(4 * Q);
    chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    chk("err_queue_drained", 32'(err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
